ifetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decoder.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- A redirect input (taken branch/jump from next-PC logic) flushes buffered and in-flight fetches.

---
 rtl/ifetch_pkg.sv | 35 +++
 rtl/ifetch_if.sv | 44 ++++
 rtl/ifetch_fifo.sv | 66 ++++++
 rtl/ifetch_unit.sv | 167 ++++++++++++++++
 tb/tb_ifetch_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the instruction fetch stage.
//   - XLEN / ILEN       : address and instruction word widths
//   - RESET_PC_DEFAULT  : default fetch address after reset
//   - ENC_* / fetch_state_e : fetch FSM state encoding
//   - ENTRY_W           : FIFO entry width ({[fault,] data, pc})
//   - word_align()      : clears the two byte-offset bits of an address
// Optional build macro: IFETCH_ALIGN_CHECK_EN (adds the fault bit to each entry).
package ifetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_WAIT = 2'd1;
    localparam logic [1:0] ENC_DROP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_WAIT = ENC_WAIT,
        ST_DROP = ENC_DROP
    } fetch_state_e;

`ifdef IFETCH_ALIGN_CHECK_EN
    localparam int ENTRY_W = 1 + ILEN + XLEN;
`else
    localparam int ENTRY_W = ILEN + XLEN;
`endif

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: bundle of the fetch stage's memory, decode and redirect signals.
//   imem_req_valid/ready, imem_addr          : request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data            : response channel from instruction memory
//   inst_valid/ready, inst_data, inst_pc     : instruction stream to decode
//   inst_fault (IFETCH_ALIGN_CHECK_EN only)  : entry was produced by a misaligned redirect
//   redirect_valid, redirect_pc              : flush and restart from next-PC logic
// Modports: master = fetch unit, slave = its environment (memory, decode, next-PC).
interface ifetch_if;
    import ifetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic            inst_fault;
`endif
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
`ifdef IFETCH_ALIGN_CHECK_EN
        output inst_fault,
`endif
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
`ifdef IFETCH_ALIGN_CHECK_EN
        input  inst_fault,
`endif
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO holding fetched instruction entries.
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared to 0)
//   push/wdata : write one entry (caller guarantees space)
//   pop        : drop head entry (caller guarantees non-empty)
//   flush      : empty the FIFO; a push in the same cycle becomes the sole entry
//   rdata      : head entry, read straight from registered storage
//   count      : occupancy 0..DEPTH
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            if (push) begin
                mem_q[0] <= wdata;
                wr_ptr_q <= PTR_W'(1);
                count_q  <= CNT_W'(1);
            end else begin
                wr_ptr_q <= '0;
                count_q  <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage feeding the decoder.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : ifetch_if.master (memory request/response, decode stream, redirect)
// Keeps at most one memory request outstanding and buffers returned words in
// ifetch_fifo. A redirect flushes the FIFO; an in-flight response is marked
// for discard (DROP).
// Optional build macro: IFETCH_ALIGN_CHECK_EN -- a misaligned redirect pushes
// a single fault entry instead of fetching and halts issue until the next
// redirect or reset. Without it, the low address bits are ignored.
//
// state | meaning
// IDLE  | no request outstanding; may issue when the FIFO has room
// WAIT  | request accepted, response pending and will be kept
// DROP  | request accepted, response pending and will be discarded
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter int              CNT_W    = 3
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);
    fetch_state_e       state_q, state_d;
    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    req_pc_q, req_pc_d;
    logic               req_valid_q, req_valid_d;
    logic               accept;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_d;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic               halt_q, halt_d;
`endif

    assign accept = req_valid_q && bus.imem_req_ready;
    // A redirect flushes the FIFO, so a simultaneous pop has nothing to act on.
    assign pop    = (count != '0) && bus.inst_ready && !bus.redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        halt_d     = halt_q;
        wdata      = {1'b0, bus.imem_rsp_data, req_pc_q};
`else
        wdata      = {bus.imem_rsp_data, req_pc_q};
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_WAIT;
                    req_pc_d   = word_align(fetch_pc_q);
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_d = ST_IDLE;
                    push    = 1'b1;
                end
            end
            ST_DROP: begin
                if (bus.imem_rsp_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.redirect_valid) begin
            fetch_pc_d = word_align(bus.redirect_pc);
            push       = 1'b0;
            // Anything accepted or still in flight belongs to the old path.
            if (state_q == ST_IDLE) begin
                state_d = accept ? ST_DROP : ST_IDLE;
            end else begin
                state_d = bus.imem_rsp_valid ? ST_IDLE : ST_DROP;
            end
`ifdef IFETCH_ALIGN_CHECK_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
                push   = 1'b1;
                wdata  = {1'b1, {ILEN{1'b0}}, bus.redirect_pc};
                halt_d = 1'b1;
            end else begin
                halt_d = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        count_d = count;
        if (bus.redirect_valid) begin
            count_d = push ? CNT_W'(1) : '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count + CNT_W'(1);
                2'b01:   count_d = count - CNT_W'(1);
                default: count_d = count;
            endcase
        end
    end

    // Request valid is registered from next-state values so it carries no
    // combinational path from the memory, decode or redirect inputs.
    always_comb begin
        req_valid_d = (state_d == ST_IDLE) && (count_d < CNT_W'(DEPTH));
`ifdef IFETCH_ALIGN_CHECK_EN
        req_valid_d = req_valid_d && !halt_d;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            halt_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
`ifdef IFETCH_ALIGN_CHECK_EN
            halt_q      <= halt_d;
`endif
        end
    end

    ifetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .rdata (rdata),
        .count (count)
    );

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_addr      = word_align(fetch_pc_q);
    assign bus.inst_valid     = (count != '0);
    assign bus.inst_pc        = rdata[XLEN-1:0];
    assign bus.inst_data      = rdata[XLEN +: ILEN];
`ifdef IFETCH_ALIGN_CHECK_EN
    assign bus.inst_fault     = rdata[ENTRY_W-1];
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic clk;
    logic rst;

    ifetch_if bus ();

    ifetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Instruction memory model: one outstanding request, fixed latency 'lat'.
    // All activity happens on the falling edge, away from the DUT's sampling edge.
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;
    int          n_acc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            pend               = 1'b0;
            n_acc              = 0;
            bus.imem_rsp_valid = 1'b0;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mword(pend_addr);
                    pend               = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend      = 1'b1;
                cnt       = lat;
                pend_addr = bus.imem_addr;
                n_acc++;
            end
        end
    end

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
    } vec_t;

    vec_t tv [21];

    task automatic do_reset();
        rst                = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            chk($sformatf("row%0d req_valid", i), 32'(bus.imem_req_valid), 32'(tv[i].req));
            chk($sformatf("row%0d imem_addr", i), bus.imem_addr, tv[i].addr);
            chk($sformatf("row%0d inst_valid", i), 32'(bus.inst_valid), 32'(tv[i].iv));
            if (tv[i].iv) begin
                chk($sformatf("row%0d inst_pc", i), bus.inst_pc, tv[i].pc);
                chk($sformatf("row%0d inst_data", i), bus.inst_data, mword(tv[i].pc));
            end
            bus.inst_ready = tv[i].rdy;
            @(negedge clk);
        end
    endtask

    initial begin : main
        int waited;
        logic found;

        rst                = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Streaming, latency 1, decode always ready.
        tv[0]  = '{1'b1, 1'b0, 32'h3000, 1'b0, 32'h0};
        tv[1]  = '{1'b1, 1'b1, 32'h3000, 1'b0, 32'h0};
        tv[2]  = '{1'b1, 1'b0, 32'h3004, 1'b0, 32'h0};
        tv[3]  = '{1'b1, 1'b1, 32'h3004, 1'b1, 32'h3000};
        tv[4]  = '{1'b1, 1'b0, 32'h3008, 1'b0, 32'h0};
        tv[5]  = '{1'b1, 1'b1, 32'h3008, 1'b1, 32'h3004};
        tv[6]  = '{1'b1, 1'b0, 32'h300C, 1'b0, 32'h0};
        tv[7]  = '{1'b1, 1'b1, 32'h300C, 1'b1, 32'h3008};
        // Fill, latency 1, decode stalled until row 19.
        tv[8]  = '{1'b0, 1'b0, 32'h3000, 1'b0, 32'h0};
        tv[9]  = '{1'b0, 1'b1, 32'h3000, 1'b0, 32'h0};
        tv[10] = '{1'b0, 1'b0, 32'h3004, 1'b0, 32'h0};
        tv[11] = '{1'b0, 1'b1, 32'h3004, 1'b1, 32'h3000};
        tv[12] = '{1'b0, 1'b0, 32'h3008, 1'b1, 32'h3000};
        tv[13] = '{1'b0, 1'b1, 32'h3008, 1'b1, 32'h3000};
        tv[14] = '{1'b0, 1'b0, 32'h300C, 1'b1, 32'h3000};
        tv[15] = '{1'b0, 1'b1, 32'h300C, 1'b1, 32'h3000};
        tv[16] = '{1'b0, 1'b0, 32'h3010, 1'b1, 32'h3000};
        tv[17] = '{1'b0, 1'b0, 32'h3010, 1'b1, 32'h3000};
        tv[18] = '{1'b0, 1'b0, 32'h3010, 1'b1, 32'h3000};
        tv[19] = '{1'b1, 1'b0, 32'h3010, 1'b1, 32'h3000};
        tv[20] = '{1'b0, 1'b1, 32'h3010, 1'b1, 32'h3004};

        #1;
        // ---- streaming ----
        lat = 1;
        do_reset();
        chk("reset inst_pc", bus.inst_pc, 32'h0);
        chk("reset inst_data", bus.inst_data, 32'h0);
        run_rows(0, 8);

        // ---- fill to DEPTH with decode stalled ----
        lat = 1;
        do_reset();
        run_rows(8, 19);
        chk("fill request count", 32'(n_acc), 32'd4);
        run_rows(19, 21);

        // ---- redirect while a latency-5 fetch of 0x3008 is in flight ----
        lat = 5;
        do_reset();
        bus.inst_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (bus.imem_req_valid && bus.imem_addr == 32'h3008) found = 1'b1;
            else @(negedge clk);
        end
        chk("lat5 saw request 0x3008", 32'(found), 32'd1);
        @(negedge clk);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("lat5 addr after redirect", bus.imem_addr, 32'h3100);
        chk("lat5 no req while dropping", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("lat5 still no req", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        chk("lat5 req after drop", 32'(bus.imem_req_valid), 32'd1);
        chk("lat5 req addr", bus.imem_addr, 32'h3100);
        chk("lat5 dropped word not pushed", 32'(bus.inst_valid), 32'd0);
        waited = 0;
        while (!bus.inst_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("lat5 first word cycles", 32'(waited), 32'd6);
        chk("lat5 first inst_pc", bus.inst_pc, 32'h3100);
        chk("lat5 first inst_data", bus.inst_data, mword(32'h3100));

        // ---- redirect coinciding with response and pop ----
        lat = 1;
        do_reset();
        repeat (4) @(negedge clk);
        chk("coinc inst_valid before", 32'(bus.inst_valid), 32'd1);
        chk("coinc inst_pc before", bus.inst_pc, 32'h3000);
        chk("coinc req_valid before", 32'(bus.imem_req_valid), 32'd0);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("coinc fifo empty", 32'(bus.inst_valid), 32'd0);
        chk("coinc req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("coinc req addr", bus.imem_addr, 32'h3100);
        @(negedge clk);
        @(negedge clk);
        chk("coinc inst_valid after", 32'(bus.inst_valid), 32'd1);
        chk("coinc inst_pc after", bus.inst_pc, 32'h3100);

        // ---- address wrap ----
        lat = 1;
        do_reset();
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("wrap req addr top", bus.imem_addr, 32'hFFFF_FFFC);
        chk("wrap req_valid", 32'(bus.imem_req_valid), 32'd1);
        @(negedge clk);
        chk("wrap next addr", bus.imem_addr, 32'h0000_0000);
        @(negedge clk);
        chk("wrap inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
        chk("wrap inst_data", bus.inst_data, mword(32'hFFFF_FFFC));
        chk("wrap req addr zero", bus.imem_addr, 32'h0000_0000);

`ifdef IFETCH_ALIGN_CHECK_EN
        // ---- misaligned redirect produces a fault entry and halts ----
        lat = 1;
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3102;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("align fault valid", 32'(bus.inst_valid), 32'd1);
        chk("align fault flag", 32'(bus.inst_fault), 32'd1);
        chk("align fault pc", bus.inst_pc, 32'h3102);
        chk("align fault data", bus.inst_data, 32'h0);
        chk("align no req", 32'(bus.imem_req_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("align still halted", 32'(bus.imem_req_valid), 32'd0);
        chk("align no mem traffic", 32'(n_acc), 32'd0);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3200;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("align resume req", 32'(bus.imem_req_valid), 32'd1);
        chk("align resume addr", bus.imem_addr, 32'h3200);
        chk("align fault flushed", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("align resume inst_pc", bus.inst_pc, 32'h3200);
        chk("align resume fault", 32'(bus.inst_fault), 32'd0);
`else
        // ---- misaligned redirect: low bits ignored ----
        lat = 1;
        do_reset();
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3102;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("noalign req addr", bus.imem_addr, 32'h3100);
        chk("noalign req_valid", 32'(bus.imem_req_valid), 32'd1);
        @(negedge clk);
        chk("noalign next addr", bus.imem_addr, 32'h3104);
        @(negedge clk);
        chk("noalign inst_pc", bus.inst_pc, 32'h3100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
